decode: RTL

Instruction decode stage for the LC3 core. It is the consumer of `fetch`: it takes the instruction word returned by instruction memory for the address `fetch` issued, and splits it into the fields that execute and `fetch` need. Those fields are opcode, PCoffset9, BR condition bits, register indices and the sign-extended immediate. It also signals completion so the controller can advance.

---
 rtl/decode.sv | 72 +++++++
 1 files changed

// File: rtl/decode.sv
// decode: LC3 instruction decode stage; optional reserved-opcode flag enabled by DECODE_ILLEGAL_TRAP_EN
module decode #(
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        decode_start,
  input  logic [15:0] pc_in,
  input  logic [15:0] mem_dout,
  output logic        busy,
  output logic        decode_done,
  output logic [15:0] ir,
  output logic [15:0] npc_out,
  output logic [3:0]  opCode_out,
  output logic [2:0]  dr,
  output logic [2:0]  sr1,
  output logic [2:0]  sr2,
  output logic        imm_sel,
  output logic [15:0] imm_out,
  output logic [8:0]  offset_out,
  output logic [2:0]  br_nzp,
  output logic        illegal_op
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, state_nx;
  logic [2:0] cnt;
  logic accept, capture;
  assign accept  = (state == IDLE) && decode_start;
  assign capture = (state == WAIT) && (cnt == 3'd0);
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  // next state and status outputs; starts outside IDLE fall through unused
  always_comb begin
    state_nx    = state;
    busy        = 1'b0;
    decode_done = 1'b0;
    state_nx    = accept ? WAIT : capture ? DONE : (state == DONE) ? IDLE : state;
    busy        = state != IDLE;
    decode_done = state == DONE;
  end
  // capture PC at request, count memory latency, latch instruction word
  always_ff @(posedge clk) begin
    if (rst) begin
      ir      <= 16'h0000;
      npc_out <= 16'h0000;
      cnt     <= 3'd0;
    end else begin
      if (accept) begin
        npc_out <= pc_in;
        cnt     <= 3'(MEM_LATENCY - 1);
      end else if (state == WAIT && cnt != 3'd0) cnt <= cnt - 3'd1;
      if (capture) ir <= mem_dout;
    end
  end
  assign opCode_out = ir[15:12];
  assign dr         = ir[11:9];
  assign sr1        = ir[8:6];
  assign sr2        = ir[2:0];
  assign imm_sel    = ir[5];
  assign imm_out    = {{11{ir[4]}}, ir[4:0]};
  assign offset_out = ir[8:0];
  assign br_nzp     = (ir[15:12] == 4'b0000) ? ir[11:9] : 3'b000;
`ifdef DECODE_ILLEGAL_TRAP_EN
  // flag reserved opcode alongside each instruction capture
  always_ff @(posedge clk) begin
    if (rst) illegal_op <= 1'b0;
    else if (capture) illegal_op <= mem_dout[15:12] == 4'b1101;
  end
`else
  assign illegal_op = 1'b0;
`endif
endmodule
